// File: rtl/mem_arbiter.sv
// Arbitrates the single memory-controller port between instruction fetch and
// data access, with data priority and a bounded fetch-starvation streak.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        mem_req_in,
    input  logic        mem_rw_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [2:0]  mem_len_in,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    output logic        mc_req_out,
    output logic        mc_rw_out,
    output logic [31:0] mc_addr_out,
    output logic [31:0] mc_wdata_out,
    output logic [2:0]  mc_len_out,
    input  logic        mc_done_in,
    input  logic [31:0] mc_rdata_in
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_MEM,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          drop_q, drop_d;

    logic        mc_req_q, mc_req_d;
    logic        mc_rw_q, mc_rw_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic [2:0]  mc_len_q, mc_len_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        if_live;
    logic        pick_if;
    logic        pick_mem;
    logic        len_ok;
    logic [31:0] rdata_masked;

    // A flush in the arbitration cycle hides the fetch request entirely.
    assign if_live  = if_req_in & ~flush_in;
    assign pick_if  = if_live & (~mem_req_in | (streak_q == LIMIT));
    assign pick_mem = mem_req_in & ~pick_if;
    assign len_ok   = (mem_len_in == 3'd1) | (mem_len_in == 3'd2) |
                      (mem_len_in == 3'd4);

    always_comb begin
        unique case (mc_len_q)
            3'd1:    rdata_masked = {24'b0, mc_rdata_in[7:0]};
            3'd2:    rdata_masked = {16'b0, mc_rdata_in[15:0]};
            default: rdata_masked = mc_rdata_in;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        mc_req_d    = mc_req_q;
        mc_rw_d     = mc_rw_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;
        mc_len_d    = mc_len_q;
        if_done_d   = 1'b0;
        if_data_d   = 32'b0;
        mem_done_d  = 1'b0;
        mem_rdata_d = 32'b0;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick_if: begin
                        mc_req_d   = 1'b1;
                        mc_rw_d    = 1'b0;
                        mc_addr_d  = if_addr_in;
                        mc_wdata_d = 32'b0;
                        mc_len_d   = 3'd4;
                        streak_d   = '0;
                        state_d    = GRANT_IF;
                    end
                    pick_mem: begin
                        if (if_live && streak_q != LIMIT) begin
                            streak_d = streak_q + SW'(1);
                        end
                        if (len_ok) begin
                            mc_req_d   = 1'b1;
                            mc_rw_d    = mem_rw_in;
                            mc_addr_d  = mem_addr_in;
                            mc_wdata_d = mem_wdata_in;
                            mc_len_d   = mem_len_in;
                            state_d    = GRANT_MEM;
                        end else begin
                            // Bad length: answer locally, controller untouched.
                            mem_done_d = 1'b1;
                            state_d    = RESP;
                        end
                    end
                    default: ;
                endcase
            end
            GRANT_IF: begin
                if (flush_in) begin
                    drop_d = 1'b1;
                end
                if (mc_done_in) begin
                    mc_req_d = 1'b0;
                    drop_d   = 1'b0;
                    state_d  = RESP;
                    if (!(drop_q || flush_in)) begin
                        if_done_d = 1'b1;
                        if_data_d = mc_rdata_in;
                    end
                end
            end
            GRANT_MEM: begin
                if (mc_done_in) begin
                    mc_req_d    = 1'b0;
                    mem_done_d  = 1'b1;
                    mem_rdata_d = mc_rw_q ? 32'b0 : rdata_masked;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            mc_req_q    <= 1'b0;
            mc_rw_q     <= 1'b0;
            mc_addr_q   <= 32'b0;
            mc_wdata_q  <= 32'b0;
            mc_len_q    <= 3'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= 32'b0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= 32'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            mc_req_q    <= mc_req_d;
            mc_rw_q     <= mc_rw_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
            mc_len_q    <= mc_len_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mc_req_out    = mc_req_q;
    assign mc_rw_out     = mc_rw_q;
    assign mc_addr_out   = mc_addr_q;
    assign mc_wdata_out  = mc_wdata_q;
    assign mc_len_out    = mc_len_q;
    assign if_done_out   = if_done_q;
    assign if_data_out   = if_data_q;
    assign mem_done_out  = mem_done_q;
    assign mem_rdata_out = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction vector table plus hand-written
// arbitration, flush, stall and reset sequences.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        mem_req_in;
    logic        mem_rw_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [2:0]  mem_len_in;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic        mc_req_out;
    logic        mc_rw_out;
    logic [31:0] mc_addr_out;
    logic [31:0] mc_wdata_out;
    logic [2:0]  mc_len_out;
    logic        mc_done_in;
    logic [31:0] mc_rdata_in;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_done_out   (if_done_out),
        .if_data_out   (if_data_out),
        .mem_req_in    (mem_req_in),
        .mem_rw_in     (mem_rw_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_len_in    (mem_len_in),
        .mem_done_out  (mem_done_out),
        .mem_rdata_out (mem_rdata_out),
        .mc_req_out    (mc_req_out),
        .mc_rw_out     (mc_rw_out),
        .mc_addr_out   (mc_addr_out),
        .mc_wdata_out  (mc_wdata_out),
        .mc_len_out    (mc_len_out),
        .mc_done_in    (mc_done_in),
        .mc_rdata_in   (mc_rdata_in)
    );

    typedef struct {
        logic        is_mem;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  len;
        logic [31:0] rdata;
        int          lat;
        logic        exp_mc;
        logic [2:0]  exp_len;
        logic        exp_rw;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        if (v.is_mem) begin
            mem_req_in   = 1'b1;
            mem_rw_in    = v.rw;
            mem_addr_in  = v.addr;
            mem_wdata_in = v.wdata;
            mem_len_in   = v.len;
        end else begin
            if_req_in  = 1'b1;
            if_addr_in = v.addr;
        end
        tick();
        if (v.exp_mc) begin
            chk("grant_req", 32'(mc_req_out), 32'd1);
            chk("mc_addr", mc_addr_out, v.addr);
            chk("mc_len", 32'(mc_len_out), 32'(v.exp_len));
            chk("mc_rw", 32'(mc_rw_out), 32'(v.exp_rw));
            if (v.exp_rw) chk("mc_wdata", mc_wdata_out, v.wdata);
            for (int i = 1; i < v.lat; i++) begin
                tick();
                chk("hold_req", 32'(mc_req_out), 32'd1);
                chk("early_done", 32'(if_done_out | mem_done_out), 32'd0);
            end
            mc_done_in  = 1'b1;
            mc_rdata_in = v.rdata;
            tick();
            mc_done_in  = 1'b0;
            mc_rdata_in = 32'h0;
            chk("req_drop", 32'(mc_req_out), 32'd0);
        end else begin
            chk("no_mc", 32'(mc_req_out), 32'd0);
        end
        chk("if_done", 32'(if_done_out), 32'(!v.is_mem));
        chk("mem_done", 32'(mem_done_out), 32'(v.is_mem));
        chk("resp_data", v.is_mem ? mem_rdata_out : if_data_out, v.exp_data);
        if_req_in  = 1'b0;
        mem_req_in = 1'b0;
        tick();
        chk("pulse_end", 32'({if_done_out, mem_done_out}), 32'd0);
        chk("data_end", if_data_out | mem_rdata_out, 32'd0);
    endtask

    // One arbitration round with both sides requesting; IF keeps re-requesting.
    task automatic arb_round(input logic exp_if);
        tick();
        chk("arb_grant", mc_addr_out, exp_if ? 32'h200 : 32'h400);
        mc_done_in  = 1'b1;
        mc_rdata_in = 32'h0000_5A5A;
        tick();
        mc_done_in = 1'b0;
        chk("arb_done", 32'({if_done_out, mem_done_out}), exp_if ? 32'd2 : 32'd1);
        if (exp_if) if_req_in = 1'b0;
        else mem_req_in = 1'b0;
        tick();
        if_req_in  = 1'b1;
        mem_req_in = 1'b1;
    endtask

    task automatic set_arb_inputs(input logic [31:0] maddr);
        if_addr_in  = 32'h200;
        mem_addr_in = maddr;
        mem_rw_in   = 1'b0;
        mem_len_in  = 3'd4;
        if_req_in   = 1'b1;
        mem_req_in  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 3'd0, 32'h00A00093, 5,
                    1'b1, 3'd4, 1'b0, 32'h00A00093};
        vecs[1] = '{1'b1, 1'b0, 32'h30004, 32'h0, 3'd1, 32'hFFFFFF85, 2,
                    1'b1, 3'd1, 1'b0, 32'h00000085};
        vecs[2] = '{1'b1, 1'b0, 32'h30004, 32'h0, 3'd2, 32'hFFFFFF85, 3,
                    1'b1, 3'd2, 1'b0, 32'h0000FF85};
        vecs[3] = '{1'b1, 1'b0, 32'h30008, 32'h0, 3'd4, 32'hDEADBEEF, 1,
                    1'b1, 3'd4, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h30010, 32'h1234ABCD, 3'd2, 32'hFFFFFFFF, 2,
                    1'b1, 3'd2, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h777, 32'h0, 3'd3, 32'h55, 1,
                    1'b0, 3'd0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h778, 32'h9, 3'd0, 32'h55, 1,
                    1'b0, 3'd0, 1'b0, 32'h0};

        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        flush_in     = 1'b0;
        if_req_in    = 1'b0;
        if_addr_in   = 32'h0;
        mem_req_in   = 1'b0;
        mem_rw_in    = 1'b0;
        mem_addr_in  = 32'h0;
        mem_wdata_in = 32'h0;
        mem_len_in   = 3'd0;
        mc_done_in   = 1'b0;
        mc_rdata_in  = 32'h0;
        repeat (2) tick();
        chk("rst_ctrl", 32'({mc_req_out, mc_rw_out, if_done_out, mem_done_out}),
            32'd0);
        chk("rst_mc_addr", mc_addr_out, 32'd0);
        chk("rst_len", 32'(mc_len_out), 32'd0);
        chk("rst_data", if_data_out | mem_rdata_out | mc_wdata_out, 32'd0);
        rst_in = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Flush in the arbitration cycle masks the fetch.
        if_addr_in = 32'h100;
        if_req_in  = 1'b1;
        flush_in   = 1'b1;
        tick();
        chk("flush_mask", 32'(mc_req_out), 32'd0);
        flush_in = 1'b0;
        tick();
        chk("if_after_mask", 32'(mc_req_out), 32'd1);
        mc_done_in  = 1'b1;
        mc_rdata_in = 32'h13;
        tick();
        mc_done_in = 1'b0;
        chk("mask_if_done", 32'(if_done_out), 32'd1);
        if_req_in = 1'b0;
        tick();

        // Flush during GRANT_IF with a data request waiting behind it.
        if_addr_in = 32'h300;
        if_req_in  = 1'b1;
        tick();
        chk("flush_grant", mc_addr_out, 32'h300);
        mem_addr_in = 32'h500;
        mem_rw_in   = 1'b0;
        mem_len_in  = 3'd4;
        mem_req_in  = 1'b1;
        tick();
        flush_in  = 1'b1;
        if_req_in = 1'b0;
        tick();
        flush_in = 1'b0;
        tick();
        chk("flushed_hold", 32'(mc_req_out), 32'd1);
        mc_done_in  = 1'b1;
        mc_rdata_in = 32'hCAFE;
        tick();
        mc_done_in = 1'b0;
        chk("flush_no_pulse", 32'({if_done_out, mem_done_out}), 32'd0);
        chk("flush_req_drop", 32'(mc_req_out), 32'd0);
        tick();
        chk("wait_e1p1", 32'(mc_req_out), 32'd0);
        tick();
        chk("grant_e1p2", 32'(mc_req_out), 32'd1);
        chk("grant_e1p2_addr", mc_addr_out, 32'h500);
        mc_done_in  = 1'b1;
        mc_rdata_in = 32'h77;
        tick();
        mc_done_in = 1'b0;
        chk("waiting_mem_done", 32'(mem_done_out), 32'd1);
        chk("waiting_mem_data", mem_rdata_out, 32'h77);
        mem_req_in = 1'b0;
        tick();

        // Drop flag must not swallow the next fetch.
        do_txn(vecs[0]);

        // Starvation bound with limit 2.
        set_arb_inputs(32'h400);
        arb_round(1'b0);
        arb_round(1'b0);
        arb_round(1'b1);
        arb_round(1'b0);
        arb_round(1'b0);
        arb_round(1'b1);
        if_req_in  = 1'b0;
        mem_req_in = 1'b0;
        tick();

        // Stall mid-GRANT_MEM, then async reset.
        set_arb_inputs(32'h600);
        tick();
        chk("stall_grant", mc_addr_out, 32'h600);
        rdy_in      = 1'b0;
        mc_done_in  = 1'b1;
        mc_rdata_in = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", 32'(mc_req_out), 32'd1);
            chk("stall_done", 32'(mem_done_out), 32'd0);
        end
        rdy_in     = 1'b1;
        mc_done_in = 1'b0;
        tick();
        chk("post_stall_req", 32'(mc_req_out), 32'd1);
        chk("post_stall_done", 32'(mem_done_out), 32'd0);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_ctrl", 32'({mc_req_out, mc_rw_out, if_done_out, mem_done_out}),
            32'd0);
        chk("arst_addr", mc_addr_out, 32'd0);
        chk("arst_len", 32'(mc_len_out), 32'd0);
        tick();
        rst_in      = 1'b0;
        mem_addr_in = 32'h400;
        arb_round(1'b0);
        arb_round(1'b0);
        arb_round(1'b1);
        if_req_in  = 1'b0;
        mem_req_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
